// File: rtl/neo_ctrl_pkg.sv
// Shared types and constants for the Neo instruction sequencer.
package neo_ctrl_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_REQ       = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ERR       = 3'd5
    } seq_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_REQ  = 2'd1;
    localparam logic [1:0] ERR_REL  = 2'd2;
    localparam logic [1:0] ERR_DONE = 2'd3;

endpackage

// File: rtl/neo_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous chip-side bit.
module neo_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/neo_instr_sequencer.sv
// Downloads instruction chunks to a Neo chip over a 4-phase req/ack
// handshake, then starts execution and waits for the chip to finish.
module neo_instr_sequencer
    import neo_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [INSTR_W-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               instruction_req,
    output logic [INSTR_W-1:0] instruction_chunked,
    input  logic               instruction_ack,
    output logic               exe_end_signal,
    input  logic               chip_done_signal,
    output logic               busy,
    output logic               done_pulse,
    output logic               error,
    output logic [1:0]         err_state,
    input  logic               clear_err,
    output logic [CNT_W-1:0]   chunk_cnt
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic               req_q, req_d;
    logic               exe_q, exe_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [1:0]         err_st_q, err_st_d;
    logic               done_q, done_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               s_ready_q, busy_q;
    logic               ack_s, done_s;
    logic               tmo_hit_s, in_wait_s;

    neo_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d_i (instruction_ack),
        .q_o (ack_s)
    );

    neo_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
        .clk (clk),
        .rst (rst),
        .d_i (chip_done_signal),
        .q_o (done_s)
    );

    // Next-state logic; a true exit condition always beats the timeout.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        exe_d     = exe_q;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_st_d  = err_st_q;
        done_d    = 1'b0;
        tmo_hit_s = (tmo_q == TMO_LAST);
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    data_d  = s_data;
                    last_d  = s_last;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                req_d   = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (tmo_hit_s) begin
                    req_d    = 1'b0;
                    exe_d    = 1'b0;
                    err_d    = 1'b1;
                    err_st_d = ERR_REQ;
                    state_d  = ST_ERR;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    if (last_q) begin
                        exe_d   = 1'b1;
                        state_d = ST_WAIT_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    req_d    = 1'b0;
                    exe_d    = 1'b0;
                    err_d    = 1'b1;
                    err_st_d = ERR_REL;
                    state_d  = ST_ERR;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_s) begin
                    exe_d   = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (tmo_hit_s) begin
                    req_d    = 1'b0;
                    exe_d    = 1'b0;
                    err_d    = 1'b1;
                    err_st_d = ERR_DONE;
                    state_d  = ST_ERR;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_ERR: begin
                if (clear_err) begin
                    err_d    = 1'b0;
                    err_st_d = ERR_NONE;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                req_d   = 1'b0;
                exe_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Timeout counter restarts on every entry into a wait state.
        in_wait_s = (state_d == ST_REQ) || (state_d == ST_RELEASE) ||
                    (state_d == ST_WAIT_DONE);
        if (in_wait_s && (state_d == state_q)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end
    end

    // State and output registers; reset abandons any program in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            exe_q     <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_st_q  <= ERR_NONE;
            done_q    <= 1'b0;
            tmo_q     <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            exe_q     <= exe_d;
            data_q    <= data_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_st_q  <= err_st_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            s_ready_q <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign s_ready             = s_ready_q;
    assign instruction_req     = req_q;
    assign instruction_chunked = data_q;
    assign exe_end_signal      = exe_q;
    assign busy                = busy_q;
    assign done_pulse          = done_q;
    assign error               = err_q;
    assign err_state           = err_st_q;
    assign chunk_cnt           = cnt_q;

endmodule

// File: tb/tb_neo_instr_sequencer.sv
// Directed bench for neo_instr_sequencer with a small chip responder.
module tb_neo_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        instruction_req;
    logic [31:0] instruction_chunked;
    logic        instruction_ack;
    logic        exe_end_signal;
    logic        chip_done_signal;
    logic        busy;
    logic        done_pulse;
    logic        error;
    logic [1:0]  err_state;
    logic        clear_err = 1'b0;
    logic [15:0] chunk_cnt;

    // chip model controls
    logic chip_en = 1'b0, auto_mode = 1'b1, ack_ok = 1'b1, done_ok = 1'b1;
    logic ack_auto = 1'b0, done_auto = 1'b0, ack_man = 1'b0, done_man = 1'b0;
    int   c_ack = 0, c_rel = 0, c_done = 0;

    // monitor state
    logic [31:0] captured[$];
    logic        req_prev = 1'b0, exe_prev = 1'b0;
    logic [31:0] held = 32'h0;
    int          stable_err = 0, ready_viol = 0, pulse_cnt = 0, exe_rise_size = 0;

    int n_checks = 0;
    int n_pass = 0;
    int base = 0;

    assign instruction_ack  = auto_mode ? ack_auto  : ack_man;
    assign chip_done_signal = auto_mode ? done_auto : done_man;

    neo_instr_sequencer #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_valid             (s_valid),
        .s_data              (s_data),
        .s_last              (s_last),
        .s_ready             (s_ready),
        .instruction_req     (instruction_req),
        .instruction_chunked (instruction_chunked),
        .instruction_ack     (instruction_ack),
        .exe_end_signal      (exe_end_signal),
        .chip_done_signal    (chip_done_signal),
        .busy                (busy),
        .done_pulse          (done_pulse),
        .error               (error),
        .err_state           (err_state),
        .clear_err           (clear_err),
        .chunk_cnt           (chunk_cnt)
    );

    always #5 clk = ~clk;

    // Chip responder: ack 3 cycles after req, release 2 cycles after req
    // falls, done 10 cycles after exe_end.
    always @(posedge clk) begin
        if (!chip_en) begin
            ack_auto  <= 1'b0;
            done_auto <= 1'b0;
            c_ack     <= 0;
            c_rel     <= 0;
            c_done    <= 0;
        end else begin
            c_ack <= (instruction_req && !ack_auto) ? c_ack + 1 : 0;
            if (instruction_req && !ack_auto && c_ack == 2 && ack_ok) ack_auto <= 1'b1;
            c_rel <= (!instruction_req && ack_auto) ? c_rel + 1 : 0;
            if (!instruction_req && ack_auto && c_rel == 1) ack_auto <= 1'b0;
            c_done <= (exe_end_signal && !done_auto) ? c_done + 1 : 0;
            if (exe_end_signal && !done_auto && c_done == 9 && done_ok) done_auto <= 1'b1;
            if (!exe_end_signal && done_auto) done_auto <= 1'b0;
        end
    end

    // Protocol monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (instruction_req && !req_prev) captured.push_back(instruction_chunked);
        if (instruction_req && req_prev && instruction_chunked !== held) stable_err <= stable_err + 1;
        if (instruction_req && s_ready) ready_viol <= ready_viol + 1;
        if (done_pulse) pulse_cnt <= pulse_cnt + 1;
        if (exe_end_signal && !exe_prev) exe_rise_size <= captured.size();
        if (instruction_req) held <= instruction_chunked;
        req_prev <= instruction_req;
        exe_prev <= exe_end_signal;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a chunk at a falling edge and hold it until the accept edge.
    task automatic send_chunk(input logic [31:0] d, input logic l, input logic hold);
        bit ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = l;
            if (s_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
    endtask

    // Bounded wait for a DUT output to go high.
    task automatic wait_sig(input int sel, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = instruction_req;
                1:       hit = exe_end_signal;
                2:       hit = done_pulse;
                3:       hit = error;
                default: hit = 1'b0;
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_req", 32'(instruction_req), 32'd0);
        check("rst_exe", 32'(exe_end_signal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_state", 32'(err_state), 32'd0);
        check("rst_cnt", 32'(chunk_cnt), 32'd0);
        check("rst_data", instruction_chunked, 32'd0);
        check("rst_pulse", 32'(done_pulse), 32'd0);
        chip_en = 1'b1;

        // single chunk
        send_chunk(32'hDEAD_BEEF, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_setup_req", 32'(instruction_req), 32'd0);
        check("t1_cnt", 32'(chunk_cnt), 32'd1);
        check("t1_data", instruction_chunked, 32'hDEAD_BEEF);
        check("t1_ready_low", 32'(s_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_req_high", 32'(instruction_req), 32'd1);
        wait_sig(1, "t1_exe_wait");
        check("t1_captured", captured[0], 32'hDEAD_BEEF);
        wait_sig(2, "t1_done_wait");
        check("t1_exe_drop", 32'(exe_end_signal), 32'd0);
        check("t1_cnt_clr", 32'(chunk_cnt), 32'd0);
        @(negedge clk);
        check("t1_pulse_1cyc", 32'(done_pulse), 32'd0);
        check("t1_pulse_cnt", 32'(pulse_cnt), 32'd1);

        // three chunks, s_valid held high across handshakes
        base = captured.size();
        send_chunk(32'h0000_00A1, 1'b0, 1'b1);
        send_chunk(32'h0000_00B2, 1'b0, 1'b1);
        send_chunk(32'h0000_00C3, 1'b1, 1'b0);
        wait_sig(2, "t2_done_wait");
        @(negedge clk);
        check("t2_count", 32'(captured.size() - base), 32'd3);
        check("t2_chunk0", captured[base], 32'h0000_00A1);
        check("t2_chunk1", captured[base + 1], 32'h0000_00B2);
        check("t2_chunk2", captured[base + 2], 32'h0000_00C3);
        check("t2_exe_after3", 32'(exe_rise_size - base), 32'd3);
        check("t2_pulse_cnt", 32'(pulse_cnt), 32'd2);

        // ack timeout
        ack_ok = 1'b0;
        send_chunk(32'h1234_5678, 1'b1, 1'b0);
        repeat (17) @(negedge clk);
        check("t3_req_last", 32'(instruction_req), 32'd1);
        check("t3_no_err_yet", 32'(error), 32'd0);
        @(negedge clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_err_state", 32'(err_state), 32'd1);
        check("t3_req_drop", 32'(instruction_req), 32'd0);
        check("t3_ready_err", 32'(s_ready), 32'd0);
        check("t3_cnt_hold", 32'(chunk_cnt), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t3_err_clr", 32'(error), 32'd0);
        check("t3_err_state_clr", 32'(err_state), 32'd0);
        check("t3_ready", 32'(s_ready), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_cnt_clr", 32'(chunk_cnt), 32'd0);

        // done timeout
        ack_ok  = 1'b1;
        done_ok = 1'b0;
        send_chunk(32'hCAFE_0001, 1'b1, 1'b0);
        wait_sig(1, "t4_exe_wait");
        wait_sig(3, "t4_err_wait");
        check("t4_err_state", 32'(err_state), 32'd3);
        check("t4_exe_drop", 32'(exe_end_signal), 32'd0);
        @(negedge clk);
        check("t4_no_pulse", 32'(pulse_cnt), 32'd2);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        done_ok   = 1'b1;

        // reset mid-handshake
        ack_ok = 1'b0;
        send_chunk(32'h5555_AAAA, 1'b1, 1'b0);
        wait_sig(0, "t5_req_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_req", 32'(instruction_req), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cnt", 32'(chunk_cnt), 32'd0);
        check("t5_exe", 32'(exe_end_signal), 32'd0);
        ack_ok = 1'b1;
        send_chunk(32'h0BAD_F00D, 1'b1, 1'b0);
        wait_sig(2, "t5_done_wait");
        check("t5_last_chunk", captured[captured.size() - 1], 32'h0BAD_F00D);
        @(negedge clk);
        check("t5_pulse_cnt", 32'(pulse_cnt), 32'd3);

        // ack_s rises in the timeout cycle: exit wins
        auto_mode = 1'b0;
        send_chunk(32'h7777_0007, 1'b1, 1'b0);
        repeat (15) @(negedge clk);
        ack_man = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_req_tmo_cycle", 32'(instruction_req), 32'd1);
        @(negedge clk);
        check("t6_req_drop", 32'(instruction_req), 32'd0);
        check("t6_no_error", 32'(error), 32'd0);
        ack_man = 1'b0;
        wait_sig(1, "t6_exe_wait");
        done_man = 1'b1;
        wait_sig(2, "t6_done_wait");
        done_man = 1'b0;
        check("t6_error_final", 32'(error), 32'd0);

        // global protocol properties
        check("data_stable", 32'(stable_err), 32'd0);
        check("ready_low_in_hs", 32'(ready_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
